// File: rtl/rp2a03_alu_seq.sv
// rp2a03_alu_seq
//
// Multi-cycle ALU for the CPU datapath. It splits DATA_W-bit operands into
// SLICE_W-bit slices and processes one slice per clock. A link bit carries the
// carry, or the shifted-out bit, from one slice to the next. It is used for
// 8-bit ALU operations and for 16-bit address arithmetic.
//
// Operations: ADD, SUB (6502 SBC), AND, EOR, OR, ASL, LSR, ROL, ROR, CMP,
// INC and DEC. Opcodes 12-15 are reserved. Each operation also produces the
// N/Z/C/V status flags.
//
// Optional feature macro: RP2A03_ALU_BCD_EN
//   When it is defined, ADD and SUB apply a per-nibble decimal adjust if
//   'decimal' was latched high. When it is undefined (the NES build),
//   'decimal' is ignored.
//
// Ports:
//   clk, rst_n           rising-edge clock; asynchronous active-low reset
//   in_valid / in_ready  request handshake; in_ready is high only in IDLE
//   op, a, b             opcode and operands; latched when a request is accepted
//   carry_in             carry/borrow-in; also the fill bit for rotates
//   decimal              decimal-mode request (used only with the macro)
//   out_valid/out_ready  result handshake; out_valid is high in DONE
//   result               DATA_W-bit result
//   flag_c/v/n/z         status flags, held until the next operation completes
module rp2a03_alu_seq #(
    parameter int DATA_W  = 8,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    input  logic              decimal,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_n,
    output logic              flag_z
);

    localparam int N_SLICES = DATA_W / SLICE_W;
    localparam int K_W      = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_SLICES - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,
                           OP_EOR = 4'd3,  OP_OR  = 4'd4,  OP_ASL = 4'd5,
                           OP_LSR = 4'd6,  OP_ROL = 4'd7,  OP_ROR = 4'd8,
                           OP_CMP = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;

    if ((SLICE_W < 1) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_width
        $error("rp2a03_alu_seq: DATA_W must be a multiple of SLICE_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
    logic              link_q, link_d;
    logic              c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;
    logic              dec_q, dec_d;

    logic [K_W-1:0]    idx;
    logic [31:0]       shamt;
    logic [SLICE_W-1:0] a_s, b_s, b_eff, slice_out;
    logic [SLICE_W:0]  sum, lsh, rsh;
    logic              link_n, v_slice, bcd_active;
    logic [DATA_W-1:0] acc_next;

`ifdef RP2A03_ALU_BCD_EN
    if ((SLICE_W % 4) != 0) begin : g_bad_bcd
        $error("rp2a03_alu_seq: decimal mode needs SLICE_W to be a multiple of 4");
    end

    // Decimal adjust, one nibble at a time. For subtraction, y is already
    // complemented. A nibble that produced no carry (a borrow) gets 6
    // subtracted from it, which is the same as adding 10 modulo 16.
    function automatic logic [SLICE_W:0] bcd_adjust(input logic [SLICE_W-1:0] x,
                                                    input logic [SLICE_W-1:0] y,
                                                    input logic cin,
                                                    input logic sub);
        logic [SLICE_W-1:0] digits;
        logic               c;
        logic [4:0]         s;
        digits = '0;
        c      = cin;
        for (int j = 0; j < SLICE_W / 4; j++) begin
            s = {1'b0, x[j*4 +: 4]} + {1'b0, y[j*4 +: 4]} + {4'b0, c};
            if (sub) begin
                c = s[4];
                if (!c) s = s + 5'd10;
            end else if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            digits[j*4 +: 4] = s[3:0];
        end
        return {c, digits};
    endfunction
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            link_q   <= 1'b0;
            dec_q    <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            link_q   <= link_d;
            dec_q    <= dec_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            n_q      <= n_d;
            z_q      <= z_d;
        end
    end

    // Datapath for one slice. LSR and ROR walk from the MSB slice down, so
    // the bit shifted out of a higher slice fills the top of the next one.
    always_comb begin
        idx        = ((op_q == OP_LSR) || (op_q == OP_ROR)) ? (K_LAST - k_q) : k_q;
        shamt      = 32'(idx) * 32'(SLICE_W);
        a_s        = SLICE_W'(a_q >> shamt);
        b_s        = SLICE_W'(b_q >> shamt);
        case (op_q)
            OP_SUB, OP_CMP: b_eff = ~b_s;
            OP_INC:         b_eff = '0;
            OP_DEC:         b_eff = '1;
            default:        b_eff = b_s;
        endcase
        sum        = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, link_q};
        lsh        = {a_s, link_q};
        rsh        = {link_q, a_s};
        v_slice    = (a_s[SLICE_W-1] == b_eff[SLICE_W-1]) && (sum[SLICE_W-1] != a_s[SLICE_W-1]);
        bcd_active = 1'b0;
        slice_out  = a_s;
        link_n     = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: begin
                slice_out = sum[SLICE_W-1:0];
                link_n    = sum[SLICE_W];
`ifdef RP2A03_ALU_BCD_EN
                if (dec_q && ((op_q == OP_ADD) || (op_q == OP_SUB))) begin
                    bcd_active          = 1'b1;
                    {link_n, slice_out} = bcd_adjust(a_s, b_eff, link_q, op_q == OP_SUB);
                end
`endif
            end
            OP_AND: slice_out = a_s & b_s;
            OP_EOR: slice_out = a_s ^ b_s;
            OP_OR:  slice_out = a_s | b_s;
            OP_ASL, OP_ROL: begin
                slice_out = lsh[SLICE_W-1:0];
                link_n    = lsh[SLICE_W];
            end
            OP_LSR, OP_ROR: begin
                slice_out = rsh[SLICE_W:1];
                link_n    = rsh[0];
            end
            default: begin
                slice_out = a_s;
                link_n    = 1'b0;
            end
        endcase
        acc_next = (acc_q & ~({{(DATA_W-SLICE_W){1'b0}}, {SLICE_W{1'b1}}} << shamt))
                 | ({{(DATA_W-SLICE_W){1'b0}}, slice_out} << shamt);
    end

    // Sequencing and result capture. Flags are taken on the last slice. For
    // ADD and SUB, that slice is always the MSB slice.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        link_d   = link_q;
        dec_d    = dec_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
        z_d      = z_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_EXEC;
                    k_d     = '0;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    dec_d   = decimal;
                    acc_d   = '0;
                    case (op)
                        OP_ADD, OP_SUB, OP_ROL, OP_ROR: link_d = carry_in;
                        OP_CMP, OP_INC:                 link_d = 1'b1;
                        default:                        link_d = 1'b0;
                    endcase
                end
            end
            S_EXEC: begin
                acc_d  = acc_next;
                link_d = link_n;
                if (k_q == K_LAST) begin
                    state_d  = S_DONE;
                    k_d      = '0;
                    result_d = acc_next;
                    n_d      = bcd_active ? sum[SLICE_W-1] : acc_next[DATA_W-1];
                    z_d      = (acc_next == '0);
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            c_d = link_n;
                            v_d = v_slice;
                        end
                        OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: c_d = link_n;
                        OP_AND, OP_EOR, OP_OR, OP_INC, OP_DEC: ;
                        default: begin
                            n_d = 1'b0;
                            z_d = 1'b0;
                        end
                    endcase
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;

endmodule

// File: tb/tb_rp2a03_alu_seq.sv
// tb_rp2a03_alu_seq
//
// Directed testbench for rp2a03_alu_seq, built with DATA_W=16 and SLICE_W=8.
// Every expected value below was worked out by hand. The bench checks:
//   - reset state
//   - each opcode
//   - latency
//   - backpressure
//   - reset in the middle of an operation
//   - decimal mode, whose expected values follow RP2A03_ALU_BCD_EN
module tb_rp2a03_alu_seq;

    localparam int DATA_W  = 16;
    localparam int SLICE_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] a, b;
    logic              carry_in;
    logic              decimal;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              flag_c, flag_v, flag_n, flag_z;

    int checks = 0;
    int fails  = 0;

    rp2a03_alu_seq #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Waits for in_ready, issues one request, then waits for out_valid and
    // checks that it arrived two cycles after the request was accepted.
    task automatic applyStimulus(input string tag, input logic [3:0] op_i,
                                 input logic [15:0] a_i, input logic [15:0] b_i,
                                 input logic cin_i, input logic dec_i);
        int cycles;
        cycles = 0;
        while (!in_ready && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        op = op_i; a = a_i; b = b_i; carry_in = cin_i; decimal = dec_i;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'd2);
    endtask

    task automatic expectResult(input string tag, input logic [15:0] res,
                                input logic c, input logic v, input logic n, input logic z);
        checkOutput({tag, " result"}, 32'(result), 32'(res));
        checkOutput({tag, " C"}, 32'(flag_c), 32'(c));
        checkOutput({tag, " V"}, 32'(flag_v), 32'(v));
        checkOutput({tag, " N"}, 32'(flag_n), 32'(n));
        checkOutput({tag, " Z"}, 32'(flag_z), 32'(z));
    endtask

    task automatic releaseResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " back to idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [3:0] op_i,
                         input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic cin_i, input logic dec_i, input logic [15:0] res,
                         input logic c, input logic v, input logic n, input logic z);
        applyStimulus(tag, op_i, a_i, b_i, cin_i, dec_i);
        expectResult(tag, res, c, v, n, z);
        releaseResult(tag);
    endtask

    initial begin
        int cycles;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; carry_in = 1'b0; decimal = 1'b0;
        #12;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        expectResult("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        //                  op     a        b        cin   dec   result   C     V     N     Z
        runOp("add ovf", 4'd0,  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        runOp("sub brw", 4'd1,  16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        runOp("cmp eq",  4'd9,  16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        runOp("ror",     4'd8,  16'h0001, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
        runOp("lsr",     4'd6,  16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp("asl",     4'd5,  16'h8001, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        runOp("rol",     4'd7,  16'h4000, 16'h0000, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
        runOp("and",     4'd2,  16'hF0F0, 16'h0FF0, 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp("eor",     4'd3,  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        runOp("or",      4'd4,  16'h0F00, 16'h80F0, 1'b0, 1'b0, 16'h8FF0, 1'b0, 1'b0, 1'b1, 1'b0);
        runOp("inc wrap",4'd10, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        runOp("dec wrap",4'd11, 16'h0000, 16'h1234, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        runOp("add cry", 4'd0,  16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp("sub nbrw",4'd1,  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        runOp("rsvd 12", 4'd12, 16'h8000, 16'h1111, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp("rsvd 15", 4'd15, 16'h0000, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Backpressure: while the result waits for out_ready, a new request
        // must neither be accepted nor disturb the held result.
        applyStimulus("bp first", 4'd0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        op = 4'd1; a = 16'h5555; b = 16'h1111; carry_in = 1'b1; decimal = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp held result", 32'(result), 32'h3333);
            checkOutput("bp held C", 32'(flag_c), 32'd0);
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp idle in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp second accepted", 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("bp second latency", 32'(cycles), 32'd2);
        expectResult("bp second", 16'h4444, 1'b1, 1'b0, 1'b0, 1'b0);
        releaseResult("bp second");

        // Reset after the first slice of an operation. The operation must be
        // discarded, and its result must not appear after reset is released.
        op = 4'd0; a = 16'h00FF; b = 16'h0001; carry_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst result", 32'(result), 32'h0000);
        checkOutput("midrst C", 32'(flag_c), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("post rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("post rst result", 32'(result), 32'h0000);
        checkOutput("post rst in_ready", 32'(in_ready), 32'd1);

        // Decimal request. The expected values depend on how the design was built.
`ifdef RP2A03_ALU_BCD_EN
        runOp("add dec", 4'd0, 16'h0958, 16'h0043, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        runOp("add dec", 4'd0, 16'h0958, 16'h0043, 1'b0, 1'b1, 16'h099B, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
